// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO block.
package fifo_pkg;

  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_DATA_WIDTH = 8;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with a synchronous write port and a registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto plain RAM; pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock FIFO: pointer/count bookkeeping, accept logic and status flags around fifo_mem.
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  f_full,
  output logic                  f_empty
);

  if (DEPTH != 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("fifo: DEPTH (%0d) must equal 2**ADDR_WIDTH (%0d)", DEPTH, ADDR_WIDTH);
  end

  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  assign f_full  = (count == COUNT_FULL);
  assign f_empty = (count == '0);

  // Full blocks writes and empty blocks reads, so a simultaneous request at either extreme
  // degrades to the single operation that is legal.
  assign wr_acc = wr_en & ~f_full;
  assign rd_acc = rd_en & ~f_empty;

  // NOTE: default assigned first so no path leaves count_nxt unassigned (no latch).
  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule : fifo

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo: a vector table plus hand-written multi-cycle sequences.
module tb_fifo;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       f_full;
  logic       f_empty;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t vecs [8];

  fifo dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .din     (din),
    .dout    (dout),
    .f_full  (f_full),
    .f_empty (f_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests and sample #1 after the rising edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'hxx;
  endtask

  task automatic check_state(input string name, input logic [7:0] exp_dout,
                             input logic exp_full, input logic exp_empty);
    check({name, " dout"},  32'(dout),    32'(exp_dout));
    check({name, " full"},  32'(f_full),  32'(exp_full));
    check({name, " empty"}, 32'(f_empty), 32'(exp_empty));
  endtask

  initial begin
    n_rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    // Reset held for three edges, then released.
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    check_state("reset", 8'h00, 1'b0, 1'b1);

    // Basic order and read-when-empty.
    vecs[0] = '{1'b1, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'hBB, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'hCC, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'hAA, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hBB, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'hCC, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'hCC, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'hCC, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_state($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full, vecs[i].exp_empty);
    end

    // Fill to full, overflow write ignored, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      check($sformatf("fill%0d full", i), 32'(f_full), 32'(i == 15));
      check($sformatf("fill%0d empty", i), 32'(f_empty), 32'd0);
    end
    step(1'b1, 1'b0, 8'hFF);
    check_state("overflow", 8'hCC, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d dout", i), 32'(dout), 32'(i));
      check($sformatf("drain%0d empty", i), 32'(f_empty), 32'(i == 15));
    end

    // Occupancy 5, then 20 cycles of simultaneous read/write across the pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'h25 + 8'(i));
      check_state($sformatf("rw%0d", i), 8'h20 + 8'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("rwdrain%0d dout", i), 32'(dout), 32'(8'h34 + 8'(i)));
    end
    check("rwdrain empty", 32'(f_empty), 32'd1);

    // Both requests while empty: write only.
    step(1'b1, 1'b1, 8'h77);
    check_state("empty_rw", 8'h38, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    check_state("empty_rw read", 8'h77, 1'b0, 1'b1);

    // Both requests while full: read only, 0xEE never stored.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
    check("full again", 32'(f_full), 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    check_state("full_rw", 8'h80, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("full_rw drain%0d", i), 32'(dout), 32'(8'h80 + 8'(i)));
    end
    check("full_rw empty", 32'(f_empty), 32'd1);

    // Reset mid-operation with a concurrent write request.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
    check("pre-reset empty", 32'(f_empty), 32'd0);
    n_rst = 1'b1;
    step(1'b1, 1'b0, 8'h99);
    n_rst = 1'b0;
    check_state("mid reset", 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h5A);
    check("post-reset write empty", 32'(f_empty), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check_state("post-reset read", 8'h5A, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fifo
